// File: rtl/lsu_bytelane.sv
// rtl/lsu_bytelane.sv - load/store byte-lane unit with optional two-beat misaligned split
module lsu_bytelane #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int MISALIGN = 1
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_adr,
  output logic [XLEN/8-1:0] bus_wren,
  output logic [XLEN-1:0]   bus_do,
  input  logic [XLEN-1:0]   bus_di,
  input  logic              bus_ack
);

  localparam int NB  = XLEN / 8;
  localparam int OB  = $clog2(NB);
  localparam int SHW = OB + 4;

  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP} state_e;

  state_e              state_q, state_d;
  logic                gap_q, gap_d;
  logic                fault_q, fault_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [XLEN-1:0]     asm_q, asm_d;

  logic                req_illegal, req_cross, req_fault;
  logic [OB-1:0]       off_q;
  logic [3:0]          n_q;
  logic                cross_q;
  logic [SHW-1:0]      sh_lo, sh_hi;
  logic [2*NB-1:0]     bmask, mask_full;
  logic [2*XLEN-1:0]   data_full;
  logic [ADDR_W-1:0]   adr_aligned;
  logic [XLEN-1:0]     load_ext;
  logic                beat1_act;

  function automatic logic [3:0] size_bytes(input logic [1:0] s);
    return 4'd1 << s;
  endfunction

  // Classify the incoming request: illegal size or lane-crossing without split support faults
  always_comb begin
    req_illegal = (req_size == 2'd3) && (XLEN == 32);
    req_cross   = (int'(req_adr[OB-1:0]) + int'(size_bytes(req_size))) > NB;
    req_fault   = req_illegal || (req_cross && (MISALIGN == 0));
  end

  // Lane geometry of the captured request: byte mask and write data spread over two bus words
  always_comb begin
    off_q       = adr_q[OB-1:0];
    n_q         = size_bytes(size_q);
    cross_q     = (int'(off_q) + int'(n_q)) > NB;
    sh_lo       = {1'b0, off_q, 3'b000};
    sh_hi       = SHW'(XLEN) - sh_lo;
    adr_aligned = {adr_q[ADDR_W-1:OB], {OB{1'b0}}};
    bmask       = '0;
    for (int i = 0; i < 2*NB; i++) bmask[i] = (i < int'(n_q));
    mask_full   = bmask << off_q;
    data_full   = {{XLEN{1'b0}}, wdata_q} << sh_lo;
  end

  // Realign the assembled load: keep n bytes, sign- or zero-fill the rest
  always_comb begin : ext_blk
    int   msb;
    logic sbit;
    msb = 8 * int'(n_q) - 1;
    if (msb > XLEN - 1) msb = XLEN - 1;
    sbit = 1'b0;
    for (int i = 0; i < XLEN; i++) if (i == msb) sbit = asm_q[i];
    sbit = sbit & ~uns_q;
    for (int i = 0; i < XLEN; i++) load_ext[i] = (i <= msb) ? asm_q[i] : sbit;
  end

  // Next-state: accept, beat sequencing with a one-cycle gap before the second beat, response
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    fault_d = fault_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    asm_d   = asm_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          adr_d   = req_adr;
          wdata_d = req_wdata;
          asm_d   = '0;
          gap_d   = 1'b0;
          fault_d = req_fault;
          state_d = req_fault ? S_RESP : S_BEAT0;
        end
      end
      S_BEAT0: begin
        if (bus_ack) begin
          if (!we_q) asm_d = bus_di >> sh_lo;
          if (cross_q) begin
            state_d = S_BEAT1;
            gap_d   = 1'b1;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_BEAT1: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (bus_ack) begin
          if (!we_q) asm_d = asm_q | (bus_di << sh_hi);
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured request; reset abandons any in-flight access
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      gap_q   <= 1'b0;
      fault_q <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      fault_q <= fault_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
    end
  end

  // Outputs decoded from registered state; bus fields are zero whenever no beat is active
  always_comb begin
    req_ready = (state_q == S_IDLE);
    beat1_act = (state_q == S_BEAT1) && !gap_q;
    bus_req   = (state_q == S_BEAT0) || beat1_act;
    bus_we    = 1'b0;
    bus_adr   = '0;
    bus_wren  = '0;
    bus_do    = '0;
    if (bus_req) begin
      bus_we  = we_q;
      bus_adr = beat1_act ? adr_aligned + ADDR_W'(NB) : adr_aligned;
      if (we_q) begin
        bus_wren = beat1_act ? mask_full[2*NB-1:NB] : mask_full[NB-1:0];
        bus_do   = beat1_act ? data_full[2*XLEN-1:XLEN] : data_full[XLEN-1:0];
      end
    end
    rsp_valid = (state_q == S_RESP);
    rsp_fault = rsp_valid && fault_q;
    rsp_rdata = (rsp_valid && !fault_q && !we_q) ? load_ext : '0;
  end

endmodule

// File: tb/tb_lsu_bytelane.sv
// tb/tb_lsu_bytelane.sv - randomized scoreboard bench for lsu_bytelane
module tb_lsu_bytelane;

  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_adr, req_wdata;
  logic        rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_adr, bus_do, bus_di;
  logic [3:0]  bus_wren;

  logic        nm_req_valid, nm_req_ready, nm_req_we, nm_req_unsigned;
  logic [1:0]  nm_req_size;
  logic [31:0] nm_req_adr, nm_req_wdata;
  logic        nm_rsp_valid, nm_rsp_fault;
  logic [31:0] nm_rsp_rdata;
  logic        nm_bus_req, nm_bus_we, nm_bus_ack;
  logic [31:0] nm_bus_adr, nm_bus_do, nm_bus_di;
  logic [3:0]  nm_bus_wren;

  lsu_bytelane #(.XLEN(32), .ADDR_W(32), .MISALIGN(1)) dut (
    .clk(clk), .n_reset(n_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_adr(req_adr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_adr(bus_adr), .bus_wren(bus_wren),
    .bus_do(bus_do), .bus_di(bus_di), .bus_ack(bus_ack)
  );

  lsu_bytelane #(.XLEN(32), .ADDR_W(32), .MISALIGN(0)) dut_nm (
    .clk(clk), .n_reset(n_reset),
    .req_valid(nm_req_valid), .req_ready(nm_req_ready), .req_we(nm_req_we), .req_size(nm_req_size),
    .req_unsigned(nm_req_unsigned), .req_adr(nm_req_adr), .req_wdata(nm_req_wdata),
    .rsp_valid(nm_rsp_valid), .rsp_rdata(nm_rsp_rdata), .rsp_fault(nm_rsp_fault),
    .bus_req(nm_bus_req), .bus_we(nm_bus_we), .bus_adr(nm_bus_adr), .bus_wren(nm_bus_wren),
    .bus_do(nm_bus_do), .bus_di(nm_bus_di), .bus_ack(nm_bus_ack)
  );

  typedef struct packed {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  wren;
    logic [31:0] dat;
  } beat_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
    int          acc;
    int          lat;
  } rsp_t;

  beat_t       beat_q[$];
  rsp_t        rsp_q[$];
  logic [7:0]  rmem [64];
  logic [31:0] bmem [16];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  int          force_wait = 0;
  bit          manual = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_evt(input string nm);
    compared++;
    mismatched++;
    $display("FAIL %s: event outside expected sequence", nm);
  endtask

  // Both the reference byte memory and the bus-side word memory hold the same content
  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    rmem[a[5:0]] = b;
    bmem[a[5:2]][8*a[1:0] +: 8] = b;
  endtask

  // Reference model: expected bus beats and response from byte-level access semantics
  task automatic issue(input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd);
    int n, waited;
    bit crossing, flt;
    beat_t b0, b1;
    rsp_t r;
    logic [31:0] v, ba;
    n = 1 << sz;
    crossing = (int'(a[1:0]) + n) > 4;
    flt = (sz == 2'd3);
    b0.adr = a & ~32'h3; b0.we = we; b0.wren = '0; b0.dat = '0;
    b1 = b0;
    b1.adr = b0.adr + 32'd4;
    v = '0;
    if (!flt) begin
      for (int k = 0; k < n; k++) begin
        ba = a + 32'(k);
        if (we) begin
          if (ba[31:2] == b0.adr[31:2]) begin
            b0.wren[ba[1:0]] = 1'b1;
            b0.dat[8*ba[1:0] +: 8] = wd[8*k +: 8];
          end else begin
            b1.wren[ba[1:0]] = 1'b1;
            b1.dat[8*ba[1:0] +: 8] = wd[8*k +: 8];
          end
        end else begin
          v[8*k +: 8] = rmem[ba[5:0]];
        end
      end
      if (!we && !uns && n < 4 && v[8*n-1])
        for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
    end
    r.rdata = (flt || we) ? 32'h0 : v;
    r.fault = flt;
    r.lat   = flt ? 1 : (force_wait == 0) ? (crossing ? 4 : 2) : -1;
    req_we = we; req_size = sz; req_unsigned = uns; req_adr = a; req_wdata = wd;
    req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      fail_evt("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    if (!flt) begin
      b0.wren = we ? b0.wren : 4'h0;
      beat_q.push_back(b0);
      if (crossing) beat_q.push_back(b1);
      if (we) for (int k = 0; k < n; k++) rmem[6'(a + 32'(k))] = wd[8*k +: 8];
    end
    r.acc = cyc;
    rsp_q.push_back(r);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while ((rsp_q.size() != 0 || !req_ready) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (rsp_q.size() != 0 || beat_q.size() != 0) fail_evt("drain_timeout");
  endtask

  // Bus responder: checks each new beat, checks hold stability, acks after a wait
  initial begin
    bit in_beat = 1'b0;
    int wl = 0;
    beat_t snap, e;
    bus_ack = 1'b0;
    bus_di  = '0;
    forever begin
      @(negedge clk);
      if (!manual) begin
        bus_ack = 1'b0;
        if (!n_reset) begin
          in_beat = 1'b0;
        end else if (bus_req) begin
          if (!in_beat) begin
            in_beat = 1'b1;
            snap.adr = bus_adr; snap.we = bus_we; snap.wren = bus_wren; snap.dat = bus_do;
            if (beat_q.size() == 0) begin
              fail_evt("beat_unexpected");
            end else begin
              e = beat_q.pop_front();
              chk("bus_adr", bus_adr, e.adr);
              chk("bus_we", 32'(bus_we), 32'(e.we));
              chk("bus_wren", 32'(bus_wren), 32'(e.wren));
              chk("bus_do", bus_do, e.dat);
            end
            wl = (force_wait >= 0) ? force_wait : $urandom_range(0, 3);
          end else begin
            chk("hold_adr", bus_adr, snap.adr);
            chk("hold_wren", 32'(bus_wren), 32'(snap.wren));
            chk("hold_do", bus_do, snap.dat);
            chk("hold_we", 32'(bus_we), 32'(snap.we));
          end
          if (wl == 0) begin
            bus_ack = 1'b1;
            if (bus_we) begin
              for (int l = 0; l < 4; l++)
                if (bus_wren[l]) bmem[bus_adr[5:2]][8*l +: 8] = bus_do[8*l +: 8];
              bus_di = $urandom;
            end else begin
              bus_di = bmem[bus_adr[5:2]];
            end
            in_beat = 1'b0;
          end else begin
            wl--;
            bus_di = $urandom;
          end
        end else begin
          in_beat = 1'b0;
          bus_ack = ($urandom_range(0, 3) == 0);
          bus_di  = $urandom;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every rsp_valid
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          fail_evt("rsp_unexpected");
        end else begin
          r = rsp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, r.rdata);
          chk("rsp_fault", 32'(rsp_fault), 32'(r.fault));
          if (r.lat >= 0) chk("rsp_latency", 32'(cyc - r.acc), 32'(r.lat));
        end
      end
    end
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a, wd;
    int          n;
    n_reset = 1'b0;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_adr = 0; req_wdata = 0;
    nm_req_valid = 0; nm_req_we = 0; nm_req_size = 0; nm_req_unsigned = 0;
    nm_req_adr = 0; nm_req_wdata = 0; nm_bus_ack = 0; nm_bus_di = 0;
    for (int i = 0; i < 64; i++) poke(32'(i), 8'($urandom));
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_bus_wren", 32'(bus_wren), 32'd0);
    chk("rst_bus_adr", bus_adr, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    n_reset = 1'b1;
    @(negedge clk);

    force_wait = 0;
    issue(1, 2'd0, 0, 32'd12, 32'h32);
    issue(1, 2'd0, 0, 32'd13, 32'h31);
    issue(0, 2'd0, 1, 32'd12, 32'h0);
    issue(0, 2'd0, 1, 32'd13, 32'h0);
    issue(1, 2'd0, 0, 32'h10, 32'h83);
    issue(0, 2'd0, 0, 32'h10, 32'h0);
    issue(1, 2'd1, 0, 32'h12, 32'h8001);
    issue(0, 2'd1, 1, 32'h12, 32'h0);
    issue(0, 2'd1, 0, 32'h12, 32'h0);
    issue(1, 2'd2, 0, 32'h0E, 32'hAABBCCDD);
    drain();
    poke(32'h0E, 8'hCC); poke(32'h0F, 8'hDD); poke(32'h10, 8'hAA); poke(32'h11, 8'hBB);
    issue(0, 2'd2, 0, 32'h0E, 32'h0);
    issue(0, 2'd3, 0, 32'h20, 32'h0);
    issue(1, 2'd2, 0, 32'hFFFFFFFE, 32'h12345678);
    issue(0, 2'd2, 0, 32'hFFFFFFFE, 32'h0);
    drain();

    force_wait = 3;
    issue(0, 2'd2, 0, 32'h04, 32'h0);
    issue(1, 2'd1, 0, 32'h23, 32'h5AA5);
    issue(0, 2'd1, 0, 32'h23, 32'h0);
    drain();

    force_wait = -1;
    for (int t = 0; t < 200; t++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      n  = 1 << sz;
      a  = {($urandom_range(0, 3) == 0) ? 26'($urandom) : 26'h0, 6'($urandom)};
      wd = $urandom;
      if (n < 4) wd = wd & 32'((64'd1 << (8*n)) - 1);
      issue(1'($urandom), sz, 1'($urandom), a, wd);
    end
    drain();

    nm_req_we = 1; nm_req_size = 2'd1; nm_req_adr = 32'h0F; nm_req_wdata = 32'h1234;
    nm_req_valid = 1;
    chk("nm_ready", 32'(nm_req_ready), 32'd1);
    @(negedge clk);
    nm_req_valid = 0;
    chk("nm_cross_bus_req", 32'(nm_bus_req), 32'd0);
    chk("nm_cross_rsp_valid", 32'(nm_rsp_valid), 32'd1);
    chk("nm_cross_rsp_fault", 32'(nm_rsp_fault), 32'd1);
    chk("nm_cross_rdata", nm_rsp_rdata, 32'd0);
    @(negedge clk);
    chk("nm_cross_done", 32'(nm_rsp_valid | nm_bus_req), 32'd0);
    nm_req_we = 0; nm_req_size = 2'd3; nm_req_adr = 32'h08;
    nm_req_valid = 1;
    @(negedge clk);
    nm_req_valid = 0;
    chk("nm_size3_bus_req", 32'(nm_bus_req), 32'd0);
    chk("nm_size3_fault", 32'({nm_rsp_valid, nm_rsp_fault}), 32'd3);
    @(negedge clk);

    manual = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    req_we = 0; req_size = 2'd2; req_unsigned = 0; req_adr = 32'h0E; req_valid = 1;
    chk("rr_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 0;
    chk("rr_beat0_req", 32'(bus_req), 32'd1);
    bus_ack = 1'b1; bus_di = 32'hDDCC0000;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("rr_gap_req", 32'(bus_req), 32'd0);
    @(negedge clk);
    chk("rr_beat1_req", 32'(bus_req), 32'd1);
    chk("rr_beat1_adr", bus_adr, 32'h10);
    #2 n_reset = 1'b0;
    #1;
    chk("rr_bus_req_drop", 32'(bus_req), 32'd0);
    chk("rr_bus_adr_clr", bus_adr, 32'd0);
    chk("rr_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rr_post_ready", 32'(req_ready), 32'd1);
      chk("rr_post_quiet", 32'(rsp_valid | bus_req), 32'd0);
    end
    manual = 1'b0;
    force_wait = 0;
    @(negedge clk);
    issue(0, 2'd0, 1, 32'd12, 32'h0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/lsu_bytelane.md
Name: lsu_bytelane

Overview:
Parametrised load/store byte-lane unit between the CPU data port and the SoC data bus. It converts byte, half, word and (XLEN=64) dword accesses into bus word addresses, per-byte write masks and lane-shifted write data. Loads are realigned and sign- or zero-extended. Unlike the fixed 32-bit, aligned-only data path, it is generic in XLEN and can split a misaligned access into two bus beats.

Parameters:
XLEN, 32, data width in bits; legal values 32 or 64; NB = XLEN/8 byte lanes, OB = log2(NB).
ADDR_W, 32, address width.
MISALIGN, 1, 1 = split lane-crossing accesses into two beats; 0 = report a fault for them.

Ports:
clk  in  1  clock
n_reset  in  1  asynchronous active-low reset
req_valid  in  1  CPU request strobe
req_ready  out  1  unit can accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  access size: 0 byte, 1 half, 2 word, 3 dword
req_unsigned  in  1  zero-extend the load (lbu/lhu/lwu)
req_adr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, LSB-aligned
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  XLEN  extended load data; 0 for stores and faults
rsp_fault  out  1  qualifies rsp_valid
bus_req  out  1  bus cycle request
bus_we  out  1  bus write
bus_adr  out  ADDR_W  bus address; low OB bits always 0
bus_wren  out  NB  per-byte write mask
bus_do  out  XLEN  bus write data
bus_di  in  XLEN  bus read data, valid while bus_ack is high
bus_ack  in  1  bus cycle done, 1-cycle pulse

Behaviour:
- Reset (async, n_reset=0): state IDLE; all outputs 0 except req_ready=1. Takes effect immediately, mid-beat included: bus_req drops combinationally-from-register in the same cycle. The in-flight request is lost and no rsp_valid is issued.
- States: IDLE, BEAT0, BEAT1, RESP.
- Accept: a request is accepted when req_valid and req_ready are both high. req_ready=1 only in IDLE. Request fields are registered on acceptance.
- Decode: n = 1<<size; off = adr[OB-1:0].
  - Illegal: size 3 with XLEN=32.
  - Crossing: off + n > NB.
- Fault: illegal size, or crossing with MISALIGN=0.
  - No bus cycle is issued.
  - Next cycle: rsp_valid=1, rsp_fault=1, rsp_rdata=0.
- BEAT0 (entered the cycle after accept):
  - bus_req=1, bus_adr = adr with low OB bits cleared.
  - Store: bus_we=1; bus_wren = ((1<<n)-1)<<off, truncated to NB bits; bus_do = wdata<<(8*off).
  - Load: bus_we=0, bus_wren=0, bus_do=0.
- Bus hold: all bus outputs stay stable while bus_req=1 until bus_ack. Any number of wait cycles is legal.
- After the BEAT0 ack:
  - Crossing access → BEAT1; otherwise → RESP.
  - Loads latch bus_di>>(8*off) into the low bytes of the assembly register.
- BEAT1:
  - bus_adr = aligned adr + NB (wraps modulo 2^ADDR_W).
  - bus_wren = ((1<<n)-1)>>(NB-off).
  - bus_do = wdata>>(8*(NB-off)).
  - On ack, loads OR bus_di<<(8*(NB-off)) into the assembly register.
- bus_req drops in the cycle after each ack. There are no back-to-back beats without a 1-cycle gap.
- RESP: rsp_valid=1 for exactly one cycle, rsp_fault=0, then IDLE.
  - Load data: low 8·n bits kept; upper bits sign-extended from bit 8n-1 unless req_unsigned (word loads on XLEN=32 are unchanged).
- Latency (zero-wait bus, aligned access): accept at T, bus_req at T+1, ack at T+1, rsp_valid at T+2. A split access adds 2 cycles.
- bus_ack while bus_req=0 is ignored.
- req_valid while req_ready=0 is ignored; the CPU holds the request.

Test Plan:
- XLEN=32; sb 0x32 to adr 12, then sb 0x31 to adr 13 → beat 1: bus_adr=0x0C, wren=4'b0001, do=0x00000032; beat 2: bus_adr=0x0C, wren=4'b0010, do=0x00003100; rsp_fault=0 on both.
- lbu adr 12, then lbu adr 13, bus_di=0x00003132 → rsp_rdata=0x32, then 0x31; bus_wren=0 on both.
- lb adr 0x10 with bus_di=0x00000083 → rsp_rdata=0xFFFFFF83; lhu adr 0x12 with bus_di=0x8001_0000 → rsp_rdata=0x00008001.
- MISALIGN=1; sw 0xAABBCCDD to adr 0x0E:
  - Beat 0: bus_adr=0x0C, wren=4'b1100, do=0xCCDD0000.
  - Beat 1: bus_adr=0x10, wren=4'b0011, do=0x0000AABB.
  - Then lw adr 0x0E with di 0xDDCC0000 then 0x0000BBAA → rsp_rdata=0xBBAADDCC.
- MISALIGN=0, sh to adr 0x0F → no bus_req; rsp_valid=rsp_fault=1 at T+1; XLEN=32 with size 3 → same fault.
- Ack delayed 3 cycles: bus outputs unchanged throughout. Separately, pull n_reset low during BEAT1 → bus_req=0 immediately, no rsp_valid, req_ready=1 after release.
